mux_arbiter_2to1_8bit: RTL and testbench
========================================

# mux_arbiter_2to1_8bit

Round-robin arbiter and output register that shares the 8-bit 2:1 mux between two valid/ready requesters. It drives the mux select from its grant logic and registers the selected byte into a single-entry output stage. It sits in front of any 8-bit consumer that two producers must share. It sustains one transfer per cycle and has fixed one-cycle latency.

## Interface
- BURST_LEN, 4: maximum consecutive grants to one requester under contention. Used only when MUX_ARB_BURST_EN is defined; legal range 1–15.

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in0_valid  input  1  requester 0 has a byte
- in0  input  8  requester 0 data
- in0_ready  output  1  requester 0 byte accepted this cycle (when in0_valid=1)
- in1_valid  input  1  requester 1 has a byte
- in1  input  8  requester 1 data
- in1_ready  output  1  requester 1 byte accepted this cycle (when in1_valid=1)
- sel  output  1  current-cycle grant; also the select of the internal mux (0 = in0, 1 = in1)
- mux_out  output  8  registered selected byte
- out_src  output  1  requester index of the byte in mux_out
- out_valid  output  1  mux_out holds an unconsumed byte
- out_ready  input  1  consumer accepts mux_out

## Operation
- load = !out_valid | out_ready. The output stage can take a byte this cycle.
- Winner (combinational):
  - If only one valid is high, that requester wins.
  - If both are high, the requester other than `last` wins.
  - If neither is high, sel holds the previous winner.
- sel = winner. ink_ready = load & (sel==k) & !rst. The ready signals depend combinationally on out_ready and the valids.
- Transfer from requester k occurs when ink_valid & ink_ready. On the next edge:
  - mux_out ← ink
  - out_src ← k
  - out_valid ← 1
  - last ← k
- If load=1 and no transfer occurs, out_valid ← 0 on the next edge. mux_out and out_src hold their values.
- If load=0, everything holds: mux_out, out_src, out_valid, last.
- Data is never dropped or duplicated. Each requester sees its own bytes in order.
- Reset values: out_valid=0, mux_out=8'h00, out_src=0, last=1 (so in0 wins the first tie), burst_cnt=0. sel evaluates to 0 while both valids are low after reset.

## Timing
- Latency: a byte accepted at edge N is visible on mux_out with out_valid=1 after edge N.
- Throughput: one byte per cycle while out_ready=1 and any valid is high.
- Backpressure: with out_valid=1 and out_ready=0, both readies are 0. The output is stable until accepted.
- Simultaneous consume and load: when out_ready=1 and a transfer occurs in the same cycle, the new byte replaces the old one with no bubble.
- Reset mid-operation: rst=1 forces both readies low in the same cycle. All registers take their reset values at the edge, and the in-flight output byte is discarded.
- Arbitration decisions are made only when load=1, so contention under backpressure does not change `last`.

## Configuration
- MUX_ARB_BURST_EN defined:
  - A 4-bit burst_cnt counts consecutive transfers from the same requester. It resets to 1 on a change of requester.
  - Under contention the current holder (`last`) keeps winning while burst_cnt < BURST_LEN.
  - Once burst_cnt = BURST_LEN, the other requester wins.
  - An uncontested requester may exceed BURST_LEN; the counter saturates at 15.
- MUX_ARB_BURST_EN undefined:
  - burst_cnt is absent.
  - Under contention, grants alternate strictly every transfer (equivalent to BURST_LEN=1).

## Test plan
- Reset then idle: rst=1 for 2 cycles, valids=0 → out_valid=0, mux_out=8'h00, in0_ready=in1_ready=0 during reset, sel=0 after.
- Single requester: in1_valid=1, in1=8'h5F, out_ready=1 → in1_ready=1, and after one edge mux_out=8'h5F, out_src=1, out_valid=1.
- Contention, burst off:
  - Both valids held high, in0=8'hC8, in1=8'h91, out_ready=1 → out_src sequence 0,1,0,1 and mux_out C8,91,C8,91.
  - With MUX_ARB_BURST_EN and BURST_LEN=2 → out_src sequence 0,0,1,1,0,0.
- Backpressure: byte 8'h1D loaded, then out_ready=0 for 3 cycles with both valids high → mux_out stays 8'h1D, both readies=0, `last` unchanged. Releasing out_ready loads the next winner on the same edge.
- Reset mid-stream: assert rst while out_valid=1 (mux_out=8'hEA) → readies drop immediately, and after the edge out_valid=0, mux_out=8'h00. The next tie is granted to in0.

Source files
------------

// File: rtl/mux_arbiter_2to1_8bit.sv
// Purpose : round-robin arbiter sharing one 8-bit 2:1 mux between two valid/ready
//           requesters, with a single-entry registered output stage.
// Latency : one cycle; a byte accepted at edge N is on o_mux_out after edge N.
// Backpr. : with o_out_valid=1 and i_out_ready=0 both readies are 0 and the
//           output holds; readies depend combinationally on i_out_ready.
//
// Optional feature macro: MUX_ARB_BURST_EN
//   undefined : strict alternation under contention.
//   defined   : the current holder may take up to BURST_LEN consecutive grants
//               under contention (4-bit saturating burst counter).
//
// Ports
//   i_clk, i_rst                 rising-edge clock, synchronous active-high reset
//   i_in0_valid, i_in0, o_in0_ready   requester 0 handshake and data
//   i_in1_valid, i_in1, o_in1_ready   requester 1 handshake and data
//   o_sel                        current-cycle grant / internal mux select
//   o_mux_out, o_out_src         registered byte and the requester it came from
//   o_out_valid, i_out_ready     output stage handshake
module mux_arbiter_2to1_8bit #(
   parameter int BURST_LEN = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_in0_valid,
   input  logic [7:0] i_in0,
   output logic       o_in0_ready,
   input  logic       i_in1_valid,
   input  logic [7:0] i_in1,
   output logic       o_in1_ready,
   output logic       o_sel,
   output logic [7:0] o_mux_out,
   output logic       o_out_src,
   output logic       o_out_valid,
   input  logic       i_out_ready
);

   // Elaboration-time guard on the burst length.
   if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_burst_len
      $error("BURST_LEN must be within 1..15");
   end

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic       r_out_valid;
   logic [7:0] r_mux_out;
   logic       r_out_src;
   logic       r_last;      // requester of the most recent transfer
   logic       r_sel_q;     // grant of the previous cycle, held while idle

   // ------------------------------------------------------------------
   // Combinational
   // ------------------------------------------------------------------
   logic       w_load;
   logic       w_both;
   logic       w_tie_win;
   logic       w_sel;
   logic       w_xfer;
   logic [7:0] w_mux;

   // Output stage accepts a byte when empty or being drained this cycle.
   assign w_load = !r_out_valid || i_out_ready;
   assign w_both = i_in0_valid && i_in1_valid;

`ifdef MUX_ARB_BURST_EN
   localparam logic [3:0] LP_BURST_LEN = 4'(BURST_LEN);

   logic [3:0] r_burst_cnt;

   // A zero count means no holder yet (after reset), so the tie falls to
   // the requester other than r_last, giving in0 the first tie.
   assign w_tie_win = ((r_burst_cnt == 4'd0) || (r_burst_cnt >= LP_BURST_LEN))
                      ? !r_last : r_last;
`else
   assign w_tie_win = !r_last;
`endif

   always_comb begin
      w_sel = r_sel_q;
      if (w_both) begin
         w_sel = w_tie_win;
      end else if (i_in0_valid) begin
         w_sel = 1'b0;
      end else if (i_in1_valid) begin
         w_sel = 1'b1;
      end
   end

   assign w_mux  = w_sel ? i_in1 : i_in0;

   assign o_in0_ready = w_load && !w_sel && !i_rst;
   assign o_in1_ready = w_load &&  w_sel && !i_rst;

   assign w_xfer = (i_in0_valid && o_in0_ready) || (i_in1_valid && o_in1_ready);

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_out_valid <= 1'b0;
         r_mux_out   <= 8'h00;
         r_out_src   <= 1'b0;
         r_last      <= 1'b1;
         r_sel_q     <= 1'b0;
      end else begin
         r_sel_q <= w_sel;
         // Nothing moves while the output is stalled, so contention under
         // backpressure cannot disturb r_last.
         if (w_load) begin
            if (w_xfer) begin
               r_out_valid <= 1'b1;
               r_mux_out   <= w_mux;
               r_out_src   <= w_sel;
               r_last      <= w_sel;
            end else begin
               r_out_valid <= 1'b0;
            end
         end
      end
   end

`ifdef MUX_ARB_BURST_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_burst_cnt <= 4'd0;
      end else if (w_load && w_xfer) begin
         if ((r_burst_cnt != 4'd0) && (w_sel == r_last)) begin
            // Uncontested runs may exceed BURST_LEN; saturate at 15.
            if (r_burst_cnt != 4'hF) begin
               r_burst_cnt <= r_burst_cnt + 4'd1;
            end
         end else begin
            r_burst_cnt <= 4'd1;
         end
      end
   end
`endif

   assign o_sel       = w_sel;
   assign o_mux_out   = r_mux_out;
   assign o_out_src   = r_out_src;
   assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_arbiter_2to1_8bit.sv
module tb_mux_arbiter_2to1_8bit;

`ifdef MUX_ARB_BURST_EN
   localparam int TB_BL = 2;
`else
   localparam int TB_BL = 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       in0_valid, in1_valid, out_ready;
   logic [7:0] in0, in1;
   logic       in0_ready, in1_ready, sel, out_src, out_valid;
   logic [7:0] mux_out;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mux_arbiter_2to1_8bit #(
`ifdef MUX_ARB_BURST_EN
      .BURST_LEN(2)
`else
      .BURST_LEN(4)
`endif
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_in0_valid(in0_valid), .i_in0(in0), .o_in0_ready(in0_ready),
      .i_in1_valid(in1_valid), .i_in1(in1), .o_in1_ready(in1_ready),
      .o_sel(sel), .o_mux_out(mux_out), .o_out_src(out_src),
      .o_out_valid(out_valid), .i_out_ready(out_ready)
   );

   // ---------------- behavioural model ----------------
   // Output stage as a 0/1-entry slot; arbitration by "who went last and how
   // many times in a row".
   logic       m_full = 1'b0;
   logic [7:0] m_byte = 8'h00;
   logic       m_src  = 1'b0;
   logic       m_last = 1'b1;
   int         m_run  = 0;      // consecutive grants to m_last (0 = none yet)
   logic       m_prev = 1'b0;

   function automatic logic m_winner();
      if (in0_valid && !in1_valid) return 1'b0;
      if (in1_valid && !in0_valid) return 1'b1;
      if (!in0_valid && !in1_valid) return m_prev;
      if (m_run == 0 || m_run >= TB_BL) return !m_last;
      return m_last;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every cycle, then advance the model across the coming edge.
   task automatic step();
      logic w, space, rdy0, rdy1;
      @(negedge clk);
      w     = m_winner();
      space = !m_full || out_ready;
      rdy0  = space && (w == 1'b0) && !rst;
      rdy1  = space && (w == 1'b1) && !rst;
      chk("mdl_sel",       {7'd0, sel},       {7'd0, w});
      chk("mdl_in0_ready", {7'd0, in0_ready}, {7'd0, rdy0});
      chk("mdl_in1_ready", {7'd0, in1_ready}, {7'd0, rdy1});
      chk("mdl_out_valid", {7'd0, out_valid}, {7'd0, m_full});
      if (m_full) begin
         chk("mdl_mux_out", mux_out, m_byte);
         chk("mdl_out_src", {7'd0, out_src}, {7'd0, m_src});
      end
      if (rst) begin
         m_full = 0; m_byte = 8'h00; m_src = 0; m_last = 1; m_run = 0; m_prev = 0;
      end else begin
         m_prev = w;
         if (space) begin
            if ((rdy0 && in0_valid) || (rdy1 && in1_valid)) begin
               m_byte = w ? in1 : in0;
               m_src  = w;
               m_full = 1;
               if (m_run != 0 && w == m_last) m_run = (m_run < 15) ? m_run + 1 : 15;
               else m_run = 1;
               m_last = w;
            end else begin
               m_full = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1, input logic ordy);
      rst = r; in0_valid = v0; in0 = d0; in1_valid = v1; in1 = d1; out_ready = ordy;
      #1;
   endtask

   logic [7:0] exp_src [6];
   logic [7:0] exp_dat [6];

   initial begin
`ifdef MUX_ARB_BURST_EN
      exp_src = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0};
`else
      exp_src = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
`endif
      for (int i = 0; i < 6; i++) exp_dat[i] = (exp_src[i] == 8'd0) ? 8'hC8 : 8'h91;

      // Reset then idle
      drive(1, 0, 8'h00, 0, 8'h00, 1);
      for (int i = 0; i < 2; i++) begin
         chk("rst_in0_ready", {7'd0, in0_ready}, 8'd0);
         chk("rst_in1_ready", {7'd0, in1_ready}, 8'd0);
         step();
      end
      drive(0, 0, 8'h00, 0, 8'h00, 1);
      chk("idle_sel",       {7'd0, sel},       8'd0);
      chk("idle_out_valid", {7'd0, out_valid}, 8'd0);
      chk("idle_mux_out",   mux_out,           8'h00);
      step();

      // Single requester
      drive(0, 0, 8'h00, 1, 8'h5F, 1);
      chk("single_in1_ready", {7'd0, in1_ready}, 8'd1);
      step();
      chk("single_mux_out",   mux_out,           8'h5F);
      chk("single_out_src",   {7'd0, out_src},   8'd1);
      chk("single_out_valid", {7'd0, out_valid}, 8'd1);

      // Fresh reset so the contention run starts from the reset arbitration state
      drive(1, 0, 8'h00, 0, 8'h00, 1);
      step();

      // Contention
      drive(0, 1, 8'hC8, 1, 8'h91, 1);
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("cont_src[%0d]", i), {7'd0, out_src}, exp_src[i]);
         chk($sformatf("cont_dat[%0d]", i), mux_out, exp_dat[i]);
      end

      // Backpressure
      drive(0, 1, 8'h1D, 0, 8'h00, 1);
      step();
      chk("bp_load", mux_out, 8'h1D);
      drive(0, 1, 8'hC8, 1, 8'h91, 0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_in0_ready", {7'd0, in0_ready}, 8'd0);
         chk("bp_in1_ready", {7'd0, in1_ready}, 8'd0);
         step();
         chk("bp_hold", mux_out, 8'h1D);
      end
      drive(0, 1, 8'hC8, 1, 8'h91, 1);
      chk("bp_release_in1_ready", {7'd0, in1_ready}, 8'd1);
      step();
      chk("bp_release_dat", mux_out, 8'h91);
      chk("bp_release_src", {7'd0, out_src}, 8'd1);

      // Reset mid-stream
      drive(0, 1, 8'hEA, 0, 8'h00, 1);
      step();
      chk("mid_loaded", mux_out, 8'hEA);
      drive(1, 1, 8'hEA, 0, 8'h00, 0);
      chk("mid_in0_ready", {7'd0, in0_ready}, 8'd0);
      chk("mid_in1_ready", {7'd0, in1_ready}, 8'd0);
      step();
      chk("mid_out_valid", {7'd0, out_valid}, 8'd0);
      chk("mid_mux_out",   mux_out,           8'h00);
      drive(0, 1, 8'h33, 1, 8'h44, 1);
      chk("mid_tie_sel", {7'd0, sel}, 8'd0);
      step();
      chk("mid_tie_src", {7'd0, out_src}, 8'd0);
      chk("mid_tie_dat", mux_out, 8'h33);

      // Mixed traffic, model-checked every cycle
      for (int i = 0; i < 60; i++) begin
         drive(0, 1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 3) != 0));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
